// File: rtl/io_mmio_responder.sv
// io_mmio_responder
// Peripheral end of the CPU IO address space (addr[7] = 1). Stores drive two
// output latches, a transmit FIFO and a flag-clear register; loads return the
// synchronized input ports or a status word. Load data is registered so it
// lines up with the data-RAM read in the MEM stage.
//
// Build option:
//   IO_MMIO_EDGE_CAPTURE_EN - when defined, a sticky EDGE flag records rising
//                             edges of synchronized in_port0[0] (STATUS bit2).
//                             When undefined, STATUS bit2 reads 0 and the
//                             0x8C wdata[0] clear has no effect.

module io_mmio_responder #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    // Pointer width; DEPTH is a power of two so pointers wrap on overflow.
    localparam int             PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
    localparam logic [4:0]     DEPTH_CNT = 5'(DEPTH);

    // Word index (addr[6:2]) of each decoded register.
    localparam logic [4:0] IDX_IN0    = 5'd0;  // 0x80
    localparam logic [4:0] IDX_IN1    = 5'd1;  // 0x84
    localparam logic [4:0] IDX_STATUS = 5'd2;  // 0x88
    localparam logic [4:0] IDX_CLR    = 5'd3;  // 0x8C
    localparam logic [4:0] IDX_TX     = 5'd4;  // 0x90

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   in0_meta_r;
    logic [31:0]   in0_sync_r;
    logic [31:0]   in1_meta_r;
    logic [31:0]   in1_sync_r;

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [4:0]    count_r;
    logic          tx_valid_r;
    logic [31:0]   tx_data_r;

    logic          ovf_r;
    logic [31:0]   rdata_r;
    logic [31:0]   out_port0_r;
    logic [31:0]   out_port1_r;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          sel_s;
    logic [4:0]    idx_s;
    logic          store_s;
    logic          push_req_s;
    logic          clr_wr_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic          edge_s;
    logic [4:0]    count_next_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [31:0]   head_next_s;
    logic [31:0]   status_s;
    logic [31:0]   rd_next_s;

    // Address bits outside the decoded range are intentionally ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^{addr[31:8], addr[1:0]};

    assign sel_s      = addr[7];
    assign idx_s      = addr[6:2];
    assign store_s    = sel_s & we;
    assign push_req_s = store_s & (idx_s == IDX_TX);
    assign clr_wr_s   = store_s & (idx_s == IDX_CLR);

    assign empty_s    = (count_r == 5'd0);
    assign full_s     = (count_r == DEPTH_CNT);
    // Pop only from a word already visible on tx_data: no same-cycle bypass.
    assign pop_s      = tx_valid_r & tx_ready;
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign ovf_set_s  = push_req_s & full_s & ~pop_s;
    assign ovf_clr_s  = clr_wr_s & wdata[1];

    // Next occupancy and pointer values for the FIFO.
    always_comb begin
        count_next_s  = count_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 5'd1;
            2'b01:   count_next_s = count_r - 5'd1;
            default: count_next_s = count_r;
        endcase
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Head word after this edge; the incoming word when it lands at the head slot.
    always_comb begin
        head_next_s = mem_r[rd_ptr_next_s];
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = wdata;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

`ifdef IO_MMIO_EDGE_CAPTURE_EN
    logic edge_r;
    logic in0_prev_r;
    logic edge_rise_s;
    logic edge_clr_s;

    assign edge_rise_s = in0_sync_r[0] & ~in0_prev_r;
    assign edge_clr_s  = clr_wr_s & wdata[0];
    assign edge_s      = edge_r;

    // Sticky rising-edge detector on synchronized in_port0[0]; set beats clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            edge_r     <= 1'b0;
            in0_prev_r <= 1'b0;
        end else begin
            in0_prev_r <= in0_sync_r[0];
            edge_r     <= edge_rise_s | (edge_r & ~edge_clr_s);
        end
    end
`else
    assign edge_s = 1'b0;
`endif

    // STATUS word as seen before the current edge.
    always_comb begin
        status_s      = 32'd0;
        status_s[0]   = empty_s;
        status_s[1]   = full_s;
        status_s[2]   = edge_s;
        status_s[3]   = ovf_r;
        status_s[8:4] = count_r;
    end

    // Load data mux; non-IO and unmapped addresses read as zero.
    always_comb begin
        rd_next_s = 32'd0;
        if (sel_s) begin
            case (idx_s)
                IDX_IN0:    rd_next_s = in0_sync_r;
                IDX_IN1:    rd_next_s = in1_sync_r;
                IDX_STATUS: rd_next_s = status_s;
                default:    rd_next_s = 32'd0;
            endcase
        end else begin
            rd_next_s = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Two-flop synchronizers for the asynchronous input ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            in0_meta_r <= 32'd0;
            in0_sync_r <= 32'd0;
            in1_meta_r <= 32'd0;
            in1_sync_r <= 32'd0;
        end else begin
            in0_meta_r <= in_port0;
            in0_sync_r <= in0_meta_r;
            in1_meta_r <= in_port1;
            in1_sync_r <= in1_meta_r;
        end
    end

    // FIFO storage; contents need no reset because pointers and count do.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // FIFO pointers, occupancy, valid flag and registered head word.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= 5'd0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 32'd0;
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            tx_valid_r <= (count_next_s != 5'd0);
            if (count_next_s != 5'd0) begin
                tx_data_r <= head_next_s;
            end
        end
    end

    // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_set_s | (ovf_r & ~ovf_clr_s);
        end
    end

    // Output latches and registered load data.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_port0_r <= 32'd0;
            out_port1_r <= 32'd0;
            rdata_r     <= 32'd0;
        end else begin
            rdata_r <= rd_next_s;
            if (store_s && (idx_s == IDX_IN0)) begin
                out_port0_r <= wdata;
            end
            if (store_s && (idx_s == IDX_IN1)) begin
                out_port1_r <= wdata;
            end
        end
    end

    assign rdata     = rdata_r;
    assign out_port0 = out_port0_r;
    assign out_port1 = out_port1_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;

endmodule

// File: tb/tb_io_mmio_responder.sv
// Self-checking bench for io_mmio_responder. Expected load data and expected
// FIFO words are queued when stimulus is driven and popped when the DUT
// presents them. Inputs change 1 ns after the rising edge; outputs are
// sampled at that point too.

module tb_io_mmio_responder;

    localparam int DEPTH = 4;

`ifdef IO_MMIO_EDGE_CAPTURE_EN
    localparam logic [31:0] EDGE_BIT = 32'h0000_0004;
`else
    localparam logic [31:0] EDGE_BIT = 32'h0000_0000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rd_q [$];
    logic [31:0] exp_tx_q [$];
    logic [31:0] exp;

    io_mmio_responder #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        addr  = 32'h0;
        wdata = 32'h0;
        we    = 1'b0;
    endtask

    task automatic bus_store(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        bus_idle();
    endtask

    // Issue one load and queue its expected data; caller compares after return.
    task automatic bus_load(input logic [31:0] a, input logic [31:0] e);
        exp_rd_q.push_back(e);
        addr = a;
        we   = 1'b0;
        step();
        bus_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_ready = 1'b0; in_port0 = 32'h0; in_port1 = 32'h0;
        bus_idle();
        step(); step();
        reset = 1'b0;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else n_pass++;
        n_checks++; if (tx_data !== 32'h0) $display("FAIL reset_tx_data got=%h exp=%h", tx_data, 32'h0); else n_pass++;
        n_checks++; if (out_port0 !== 32'h0 || out_port1 !== 32'h0)
            $display("FAIL reset_out_ports got=%h/%h exp=0/0", out_port0, out_port1); else n_pass++;
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL reset_status got=%h exp=%h", rdata, exp); else n_pass++;
    endtask

    task automatic test_ports();
        bus_store(32'h80, 32'h1234_5678);
        n_checks++; if (out_port0 !== 32'h1234_5678 || out_port1 !== 32'h0)
            $display("FAIL store_out0 got=%h/%h exp=12345678/00000000", out_port0, out_port1); else n_pass++;
        bus_store(32'h84, 32'hCAFE_F00D);
        n_checks++; if (out_port1 !== 32'hCAFE_F00D)
            $display("FAIL store_out1 got=%h exp=cafef00d", out_port1); else n_pass++;

        // in_port0 changes before edge K, load in cycle K+2 sees it.
        in_port0 = 32'hA5A5_A5A5;
        step(); step();
        bus_load(32'h80, 32'hA5A5_A5A5);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL in0_read got=%h exp=%h", rdata, exp); else n_pass++;

        // Back-to-back loads of IN1 across the synchronizer latency.
        in_port1 = 32'h5A5A_0001;
        bus_load(32'h84, 32'h0);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL in1_lat_k got=%h exp=%h", rdata, exp); else n_pass++;
        bus_load(32'h84, 32'h0);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL in1_lat_k1 got=%h exp=%h", rdata, exp); else n_pass++;
        bus_load(32'h84, 32'h5A5A_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL in1_lat_k2 got=%h exp=%h", rdata, exp); else n_pass++;

        // Non-IO store is ignored and the same cycle loads zero.
        exp_rd_q.push_back(32'h0);
        bus_store(32'h00, 32'hFFFF_FFFF);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL nonio_read got=%h exp=%h", rdata, exp); else n_pass++;
        n_checks++; if (out_port0 !== 32'h1234_5678 || out_port1 !== 32'hCAFE_F00D)
            $display("FAIL nonio_store got=%h/%h exp=12345678/cafef00d", out_port0, out_port1); else n_pass++;

        // Unmapped IO address: store ignored, loads zero.
        exp_rd_q.push_back(32'h0);
        bus_store(32'h98, 32'hFFFF_FFFF);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp || out_port0 !== 32'h1234_5678 || out_port1 !== 32'hCAFE_F00D)
            $display("FAIL unmapped got=%h %h/%h exp=00000000 12345678/cafef00d", rdata, out_port0, out_port1); else n_pass++;
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] words [5];
        words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (exp_tx_q.size() < DEPTH) exp_tx_q.push_back(words[i]);
            bus_store(32'h90, words[i]);
            if (i == 0) begin
                n_checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h11)
                    $display("FAIL first_push got=%b/%h exp=1/00000011", tx_valid, tx_data); else n_pass++;
            end
        end
        bus_load(32'h88, 32'h0000_0042);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL status_full got=%h exp=%h", rdata, exp); else n_pass++;
        if (exp_tx_q.size() < DEPTH) exp_tx_q.push_back(words[4]);
        bus_store(32'h90, words[4]);
        bus_load(32'h88, 32'h0000_004A);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL status_ovf got=%h exp=%h", rdata, exp); else n_pass++;
        n_checks++; if (tx_data !== 32'h11) $display("FAIL head_hold got=%h exp=00000011", tx_data); else n_pass++;

        tx_ready = 1'b1;
        for (int c = 0; c < 20 && exp_tx_q.size() > 0; c++) begin
            if (tx_valid) begin
                exp = exp_tx_q.pop_front();
                n_checks++; if (tx_data !== exp) $display("FAIL ovf_drain got=%h exp=%h", tx_data, exp); else n_pass++;
            end
            step();
        end
        tx_ready = 1'b0;
        n_checks++; if (exp_tx_q.size() != 0 || tx_valid !== 1'b0)
            $display("FAIL ovf_drain_end left=%0d tx_valid=%b exp=0/0", exp_tx_q.size(), tx_valid); else n_pass++;
        bus_load(32'h88, 32'h0000_0009);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL status_drained got=%h exp=%h", rdata, exp); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        logic [31:0] words [4];
        words = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_tx_q.push_back(words[i]);
            bus_store(32'h90, words[i]);
        end
        // Full, pop and push on the same edge.
        tx_ready = 1'b1;
        exp = exp_tx_q.pop_front();
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp)
            $display("FAIL full_pp_head got=%b/%h exp=1/%h", tx_valid, tx_data, exp); else n_pass++;
        exp_tx_q.push_back(32'h66);
        bus_store(32'h90, 32'h66);
        tx_ready = 1'b0;
        bus_load(32'h88, 32'h0000_004A);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL full_pp_status got=%h exp=%h", rdata, exp); else n_pass++;
        exp = exp_tx_q[0];
        n_checks++; if (tx_data !== exp) $display("FAIL full_pp_next got=%h exp=%h", tx_data, exp); else n_pass++;

        bus_store(32'h8C, 32'h0000_0002);
        bus_load(32'h88, 32'h0000_0042);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL ovf_clear got=%h exp=%h", rdata, exp); else n_pass++;

        tx_ready = 1'b1;
        for (int c = 0; c < 20 && exp_tx_q.size() > 0; c++) begin
            if (tx_valid) begin
                exp = exp_tx_q.pop_front();
                n_checks++; if (tx_data !== exp) $display("FAIL pp_drain got=%h exp=%h", tx_data, exp); else n_pass++;
            end
            step();
        end
        tx_ready = 1'b0;
        n_checks++; if (exp_tx_q.size() != 0 || tx_valid !== 1'b0)
            $display("FAIL pp_drain_end left=%0d tx_valid=%b exp=0/0", exp_tx_q.size(), tx_valid); else n_pass++;
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL pp_status_empty got=%h exp=%h", rdata, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        // Push into an empty FIFO with tx_ready high: stored, not bypassed.
        tx_ready = 1'b1;
        addr = 32'h90; wdata = 32'h77; we = 1'b1;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL no_bypass_pre got=%b exp=0", tx_valid); else n_pass++;
        exp_tx_q.push_back(32'h77);
        step();
        bus_idle();
        exp = exp_tx_q.pop_front();
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp)
            $display("FAIL no_bypass_post got=%b/%h exp=1/%h", tx_valid, tx_data, exp); else n_pass++;
        step();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL single_pop got=%b exp=0", tx_valid); else n_pass++;

        // Streaming: a push every cycle while the consumer pops every cycle.
        for (int i = 0; i < 4; i++) begin
            if (tx_valid) begin
                exp = exp_tx_q.pop_front();
                n_checks++; if (tx_data !== exp) $display("FAIL stream got=%h exp=%h", tx_data, exp); else n_pass++;
            end
            exp_tx_q.push_back(32'h81 + 32'(i));
            addr = 32'h90; wdata = 32'h81 + 32'(i); we = 1'b1;
            step();
        end
        bus_idle();
        for (int c = 0; c < 20 && exp_tx_q.size() > 0; c++) begin
            if (tx_valid) begin
                exp = exp_tx_q.pop_front();
                n_checks++; if (tx_data !== exp) $display("FAIL stream_drain got=%h exp=%h", tx_data, exp); else n_pass++;
            end
            step();
        end
        tx_ready = 1'b0;
        n_checks++; if (exp_tx_q.size() != 0 || tx_valid !== 1'b0)
            $display("FAIL stream_end left=%0d tx_valid=%b exp=0/0", exp_tx_q.size(), tx_valid); else n_pass++;

        // A store to STATUS is ignored and loads the current STATUS.
        exp_rd_q.push_back(32'h0000_0001);
        bus_store(32'h88, 32'hFFFF_FFFF);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL status_store got=%h exp=%h", rdata, exp); else n_pass++;
    endtask

    task automatic test_edge();
        in_port0 = 32'h0;
        step(); step(); step(); step();
        bus_store(32'h8C, 32'h0000_0001);
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL edge_base got=%h exp=%h", rdata, exp); else n_pass++;

        // Rising edge before edge K; load in K+2 is too early, K+3 sees it.
        in_port0 = 32'h1;
        step(); step();
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL edge_early got=%h exp=%h", rdata, exp); else n_pass++;
        bus_load(32'h88, 32'h0000_0001 | EDGE_BIT);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL edge_set got=%h exp=%h", rdata, exp); else n_pass++;

        // New rising edge on the same edge as a clear: set wins.
        in_port0 = 32'h0;
        step(); step(); step(); step();
        in_port0 = 32'h1;
        step(); step();
        bus_store(32'h8C, 32'h0000_0001);
        bus_load(32'h88, 32'h0000_0001 | EDGE_BIT);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL edge_set_wins got=%h exp=%h", rdata, exp); else n_pass++;
        bus_store(32'h8C, 32'h0000_0001);
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL edge_clear got=%h exp=%h", rdata, exp); else n_pass++;

        // Falling edge does not set EDGE.
        in_port0 = 32'h0;
        step(); step(); step(); step();
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL edge_falling got=%h exp=%h", rdata, exp); else n_pass++;
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        in_port0 = 32'h1;
        for (int i = 0; i < 3; i++) begin
            exp_tx_q.push_back(32'hB0 + 32'(i));
            bus_store(32'h90, 32'hB0 + 32'(i));
        end
        step();
        bus_load(32'h88, 32'h0000_0030 | EDGE_BIT);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL pre_reset_status got=%h exp=%h", rdata, exp); else n_pass++;

        // Reset with a store in the same cycle; the store must be ignored.
        reset = 1'b1;
        addr = 32'h80; wdata = 32'hDEAD_BEEF; we = 1'b1;
        step();
        reset = 1'b0;
        bus_idle();
        exp_tx_q.delete();
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0)
            $display("FAIL mid_reset_fifo got=%b/%h exp=0/00000000", tx_valid, tx_data); else n_pass++;
        n_checks++; if (out_port0 !== 32'h0 || out_port1 !== 32'h0 || rdata !== 32'h0)
            $display("FAIL mid_reset_regs got=%h/%h/%h exp=0/0/0", out_port0, out_port1, rdata); else n_pass++;
        bus_load(32'h88, 32'h0000_0001);
        exp = exp_rd_q.pop_front();
        n_checks++; if (rdata !== exp) $display("FAIL mid_reset_status got=%h exp=%h", rdata, exp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ports();
        test_fifo_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
